lsu_mem_initiator: RTL and testbench
====================================

Name: lsu_mem_initiator

Overview:
- Load/store unit that issues requests to the data-memory responder.
- Responder timing: combinational read, synchronous write on posedge, aligned SB/SH/SW and LB/LBU/LH/LHU/LW selected by funct3.
- Sits between the execute stage and data memory. Accepts one request per transaction and splits misaligned halfword/word accesses into byte accesses.
- Returns one response pulse per request: load data or store-complete, plus an error flag.

Parameters:
- MEM_BYTES, 1024: addressable bytes. A request where any touched byte is at or above MEM_BYTES is an error.
- ADDR_W, 32: width of the request and memory address.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I load/store funct3
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  load result, zero for stores and errors
- resp_err  out  1  illegal funct3, out-of-range address, or (with feature) misaligned
- mem_address  out  ADDR_W  byte address to memory
- mem_write_data  out  32  store data to memory
- mem_funct3  out  3  access size/sign to memory
- mem_read_en  out  1  memory read enable
- mem_write_en  out  1  memory write enable
- mem_read_data  in  32  formatted load data from memory

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - State goes to IDLE.
  - Outputs while in reset: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, mem_read_en=0, mem_write_en=0, mem_address=0, mem_write_data=0, mem_funct3=0.
  - mem_read_en and mem_write_en are gated low combinationally whenever rst=1, so a reset mid-transaction never completes a write.
- States: IDLE, ACCESS, SPLIT, RESP.
- IDLE:
  - req_ready=1.
  - A handshake (req_valid & req_ready) registers we/funct3/addr/wdata.
  - Next state is RESP if the request is erroneous.
  - Otherwise ACCESS if aligned (byte; halfword with addr[0]=0; word with addr[1:0]=0).
  - Otherwise SPLIT with byte counter k=0.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else is an error: no memory enable asserted, resp_err=1.
- ACCESS (1 cycle):
  - Drive mem_address=addr, mem_funct3=funct3, mem_write_data=wdata.
  - Assert mem_read_en (load) or mem_write_en (store).
  - Loads capture mem_read_data at the end of the cycle.
  - Next state RESP.
- SPLIT:
  - N = 2 for halfword, 4 for word. Each cycle is one byte access at addr+k.
  - Loads use mem_funct3=100 (LBU) and capture byte k into an assembly register.
  - Stores use mem_funct3=000 (SB) with mem_write_data={24'b0, wdata[8k+7:8k]}.
  - k increments each cycle; after k=N-1 go to RESP.
  - Assembled loads are sign- or zero-extended per the original funct3.
- RESP (1 cycle): resp_valid=1, resp_rdata/resp_err valid, req_ready=0, then IDLE.
- Latency from accept cycle c0:
  - Aligned: resp_valid at c2.
  - Misaligned halfword: c3.
  - Misaligned word: c5.
  - Error: c1.
- Response has no backpressure; the pipeline stalls on req_ready=0.
- Address arithmetic is modulo 2^ADDR_W. A split that wraps past MEM_BYTES-1 is an error, detected at accept.
- Only one outstanding request. req_valid in non-IDLE states is ignored.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: SPLIT is not used; a misaligned halfword/word request goes straight to RESP with resp_err=1 and no memory access.
- Undefined: misaligned accesses are split as described above.

Decomposition:
- Package lsu_pkg:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - State enum lsu_state_t.
  - Function for access size in bytes.
- Sub-module lsu_load_align (combinational): assembles up to 4 captured bytes plus funct3 into the final extended 32-bit load result.

Test Plan:
- Memory word 0 preloaded 0xAABBCCDD; LW addr 0 -> mem_read_en for one cycle at c1; resp_valid at c2, resp_rdata=0xAABBCCDD, resp_err=0.
- LH addr 1 (misaligned) -> two LBU reads at addresses 1 and 2; resp at c3, resp_rdata=0xFFFFBBCC. With LSU_MISALIGN_TRAP_EN defined -> resp at c1, resp_err=1, no mem_read_en.
- SW 0x11223344 at addr 5 -> four SB writes at addresses 5..8; resp at c5. Follow-up LW addr 4 returns 0x22334400; LBU addr 8 returns 0x00000011.
- Store with funct3=100, and LW at addr 1024 (MEM_BYTES=1024) -> resp at c1, resp_err=1, mem_write_en and mem_read_en never asserted.
- rst asserted during SPLIT of a word store after two bytes -> mem_write_en low that cycle; next cycle IDLE, req_ready=1; bytes 3 and 4 are not written.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - funct3 encodings, FSM state type and size helpers for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        SPLIT,
        RESP
    } lsu_state_t;

    // Bytes touched by an access; 0 for encodings that are not loads/stores at all.
    function automatic logic [2:0] access_bytes(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: access_bytes = 3'd1;
            F3_H, F3_HU: access_bytes = 3'd2;
            F3_W:        access_bytes = 3'd4;
            default:     access_bytes = 3'd0;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        if (we)
            funct3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            funct3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                           (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// rtl/lsu_mem_initiator_if.sv - request/response and data-memory bundles for the load/store unit
interface lsu_req_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_mem_if #(parameter int ADDR_W = 32);
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_write_data;
    logic [2:0]        mem_funct3;
    logic              mem_read_en;
    logic              mem_write_en;
    logic [31:0]       mem_read_data;

    modport master (
        output mem_address, mem_write_data, mem_funct3, mem_read_en, mem_write_en,
        input  mem_read_data
    );
    modport slave (
        input  mem_address, mem_write_data, mem_funct3, mem_read_en, mem_write_en,
        output mem_read_data
    );
endinterface

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - sign/zero extends bytes assembled from a split load
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] bytes_in,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata
);

    always_comb begin
        rdata = bytes_in;
        case (funct3)
            F3_B:    rdata = {{24{bytes_in[7]}}, bytes_in[7:0]};
            F3_BU:   rdata = {24'b0, bytes_in[7:0]};
            F3_H:    rdata = {{16{bytes_in[15]}}, bytes_in[15:0]};
            F3_HU:   rdata = {16'b0, bytes_in[15:0]};
            default: rdata = bytes_in;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// rtl/lsu_mem_initiator.sv - load/store unit driving data memory; LSU_MISALIGN_TRAP_EN traps misaligned accesses
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic       clk,
    input  logic       rst,
    lsu_req_if.slave   req,
    lsu_mem_if.master  mem
);

    lsu_state_t        state;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [31:0]       wdata_q;
    logic [1:0]        k_q;
    logic [1:0]        last_k_q;
    logic [31:0]       asm_q;
    logic              rd_en_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [2:0]        mem_f3_q;
    logic              resp_valid_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;

    logic [2:0]        size;
    logic              legal;
    logic              misaligned;
    logic              oob;
    logic              req_err;
    logic [ADDR_W-1:0] last_addr;
    logic [1:0]        k_next;
    logic [31:0]       asm_next;
    logic [31:0]       load_result;

    always_comb begin
        size       = access_bytes(req.req_funct3);
        legal      = funct3_legal(req.req_we, req.req_funct3);
        misaligned = ((size == 3'd2) && req.req_addr[0]) ||
                     ((size == 3'd4) && (req.req_addr[1:0] != 2'b00));
        last_addr  = req.req_addr + ADDR_W'(size) - ADDR_W'(1);
        // last_addr < req_addr catches a span that wraps past 2^ADDR_W
        oob        = (req.req_addr >= ADDR_W'(MEM_BYTES)) ||
                     (last_addr >= ADDR_W'(MEM_BYTES)) ||
                     (last_addr < req.req_addr);
`ifdef LSU_MISALIGN_TRAP_EN
        req_err    = !legal || oob || misaligned;
`else
        req_err    = !legal || oob;
`endif
    end

    // The byte arriving this cycle is merged in so the final split beat can respond directly.
    always_comb begin
        k_next   = k_q + 2'd1;
        asm_next = asm_q;
        asm_next[{k_q, 3'b000} +: 8] = mem.mem_read_data[7:0];
    end

    lsu_load_align u_load_align (
        .bytes_in (asm_next),
        .funct3   (f3_q),
        .rdata    (load_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            f3_q         <= '0;
            wdata_q      <= '0;
            k_q          <= '0;
            last_k_q     <= '0;
            asm_q        <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_f3_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b0;
                    if (req.req_valid) begin
                        we_q     <= req.req_we;
                        f3_q     <= req.req_funct3;
                        wdata_q  <= req.req_wdata;
                        k_q      <= '0;
                        asm_q    <= '0;
                        last_k_q <= (size == 3'd4) ? 2'd3 : 2'd1;
                        if (req_err) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (!misaligned) begin
                            state       <= ACCESS;
                            mem_addr_q  <= req.req_addr;
                            mem_f3_q    <= req.req_funct3;
                            mem_wdata_q <= req.req_wdata;
                            rd_en_q     <= !req.req_we;
                            wr_en_q     <= req.req_we;
                        end else begin
                            state       <= SPLIT;
                            mem_addr_q  <= req.req_addr;
                            mem_f3_q    <= req.req_we ? F3_B : F3_BU;
                            mem_wdata_q <= {24'b0, req.req_wdata[7:0]};
                            rd_en_q     <= !req.req_we;
                            wr_en_q     <= req.req_we;
                        end
                    end
                end
                ACCESS: begin
                    rd_en_q      <= 1'b0;
                    wr_en_q      <= 1'b0;
                    state        <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= we_q ? '0 : mem.mem_read_data;
                end
                SPLIT: begin
                    if (!we_q)
                        asm_q <= asm_next;
                    if (k_q == last_k_q) begin
                        rd_en_q      <= 1'b0;
                        wr_en_q      <= 1'b0;
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= we_q ? '0 : load_result;
                    end else begin
                        k_q         <= k_next;
                        mem_addr_q  <= mem_addr_q + ADDR_W'(1);
                        mem_wdata_q <= {24'b0, wdata_q[{k_next, 3'b000} +: 8]};
                    end
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req.req_ready      = (state == IDLE) && !rst;
    assign req.resp_valid     = resp_valid_q;
    assign req.resp_rdata     = resp_rdata_q;
    assign req.resp_err       = resp_err_q;
    assign mem.mem_address    = mem_addr_q;
    assign mem.mem_write_data = mem_wdata_q;
    assign mem.mem_funct3     = mem_f3_q;
    // Enables are gated by reset so an interrupted store never lands its next byte.
    assign mem.mem_read_en    = rd_en_q && !rst;
    assign mem.mem_write_en   = wr_en_q && !rst;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb/tb_lsu_mem_initiator.sv - directed bench with a byte-array data-memory responder
module tb_lsu_mem_initiator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    lsu_req_if #(.ADDR_W(32)) req_bus ();
    lsu_mem_if #(.ADDR_W(32)) mem_bus ();

    lsu_mem_initiator #(.MEM_BYTES(1024), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .req (req_bus),
        .mem (mem_bus)
    );

    always #5 clk = ~clk;

    // Responder: formatted combinational read, byte-lane write on posedge.
    bit   [7:0]  mem_b [0:1023];
    logic [9:0]  ma;
    logic [7:0]  b0, b1, b2, b3;
    assign ma = mem_bus.mem_address[9:0];
    assign b0 = mem_b[ma];
    assign b1 = mem_b[ma + 10'd1];
    assign b2 = mem_b[ma + 10'd2];
    assign b3 = mem_b[ma + 10'd3];

    always_comb begin
        mem_bus.mem_read_data = 32'h0;
        case (mem_bus.mem_funct3)
            3'b000: mem_bus.mem_read_data = {{24{b0[7]}}, b0};
            3'b100: mem_bus.mem_read_data = {24'h0, b0};
            3'b001: mem_bus.mem_read_data = {{16{b1[7]}}, b1, b0};
            3'b101: mem_bus.mem_read_data = {16'h0, b1, b0};
            3'b010: mem_bus.mem_read_data = {b3, b2, b1, b0};
            default: mem_bus.mem_read_data = 32'h0;
        endcase
    end

    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] rd_log [0:63];
    logic [31:0] wr_log [0:63];

    always @(posedge clk) begin
        if (mem_bus.mem_write_en) begin
            case (mem_bus.mem_funct3)
                3'b000: mem_b[ma] <= mem_bus.mem_write_data[7:0];
                3'b001: begin
                    mem_b[ma]         <= mem_bus.mem_write_data[7:0];
                    mem_b[ma + 10'd1] <= mem_bus.mem_write_data[15:8];
                end
                3'b010: begin
                    mem_b[ma]         <= mem_bus.mem_write_data[7:0];
                    mem_b[ma + 10'd1] <= mem_bus.mem_write_data[15:8];
                    mem_b[ma + 10'd2] <= mem_bus.mem_write_data[23:16];
                    mem_b[ma + 10'd3] <= mem_bus.mem_write_data[31:24];
                end
                default: ;
            endcase
            wr_log[wr_cnt % 64] <= mem_bus.mem_address;
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_bus.mem_read_en) begin
            rd_log[rd_cnt % 64] <= mem_bus.mem_address;
            rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_rd, input int exp_wr, input logic [31:0] exp_first);
        int rd0, wr0, lat;
        @(negedge clk);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        req_bus.req_valid  = 1'b1;
        req_bus.req_we     = we;
        req_bus.req_funct3 = f3;
        req_bus.req_addr   = addr;
        req_bus.req_wdata  = wdata;
        check_eq({tag, " ready"}, 32'(req_bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_bus.req_valid = 1'b0;
        lat = 1;
        while (!req_bus.resp_valid && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, " rdata"}, req_bus.resp_rdata, exp_rdata);
        check_eq({tag, " err"}, 32'(req_bus.resp_err), 32'(exp_err));
        check_eq({tag, " reads"}, 32'(rd_cnt - rd0), 32'(exp_rd));
        check_eq({tag, " writes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
        if (exp_rd > 0)
            check_eq({tag, " rd addr"}, rd_log[rd0 % 64], exp_first);
        if (exp_wr > 0)
            check_eq({tag, " wr addr"}, wr_log[wr0 % 64], exp_first);
    endtask

    initial begin
        int base;
        req_bus.req_valid  = 1'b0;
        req_bus.req_we     = 1'b0;
        req_bus.req_funct3 = 3'b000;
        req_bus.req_addr   = 32'h0;
        req_bus.req_wdata  = 32'h0;
        repeat (3) @(negedge clk);
        check_eq("rst ready", 32'(req_bus.req_ready), 32'd0);
        check_eq("rst resp_valid", 32'(req_bus.resp_valid), 32'd0);
        check_eq("rst rdata", req_bus.resp_rdata, 32'h0);
        check_eq("rst rd_en", 32'(mem_bus.mem_read_en), 32'd0);
        check_eq("rst wr_en", 32'(mem_bus.mem_write_en), 32'd0);
        check_eq("rst addr", mem_bus.mem_address, 32'h0);
        rst = 1'b0;

        do_req("sw0", 1, 3'b010, 32'd0, 32'hAABBCCDD, 2, 32'h0, 0, 0, 1, 32'd0);
        do_req("lw0", 0, 3'b010, 32'd0, 32'h0, 2, 32'hAABBCCDD, 0, 1, 0, 32'd0);
        do_req("lb3", 0, 3'b000, 32'd3, 32'h0, 2, 32'hFFFFFFAA, 0, 1, 0, 32'd3);
`ifdef LSU_MISALIGN_TRAP_EN
        do_req("lh1", 0, 3'b001, 32'd1, 32'h0, 1, 32'h0, 1, 0, 0, 32'd0);
        do_req("lhu1", 0, 3'b101, 32'd1, 32'h0, 1, 32'h0, 1, 0, 0, 32'd0);
        do_req("sw5", 1, 3'b010, 32'd5, 32'h11223344, 1, 32'h0, 1, 0, 0, 32'd0);
        do_req("lw4", 0, 3'b010, 32'd4, 32'h0, 2, 32'h0, 0, 1, 0, 32'd4);
        do_req("lbu8", 0, 3'b100, 32'd8, 32'h0, 2, 32'h0, 0, 1, 0, 32'd8);
`else
        base = rd_cnt;
        do_req("lh1", 0, 3'b001, 32'd1, 32'h0, 3, 32'hFFFFBBCC, 0, 2, 0, 32'd1);
        check_eq("lh1 rd addr2", rd_log[(base + 1) % 64], 32'd2);
        do_req("lhu1", 0, 3'b101, 32'd1, 32'h0, 3, 32'h0000BBCC, 0, 2, 0, 32'd1);
        base = wr_cnt;
        do_req("sw5", 1, 3'b010, 32'd5, 32'h11223344, 5, 32'h0, 0, 0, 4, 32'd5);
        for (int i = 1; i < 4; i++)
            check_eq("sw5 wr addr", wr_log[(base + i) % 64], 32'(5 + i));
        do_req("lw4", 0, 3'b010, 32'd4, 32'h0, 2, 32'h22334400, 0, 1, 0, 32'd4);
        do_req("lbu8", 0, 3'b100, 32'd8, 32'h0, 2, 32'h00000011, 0, 1, 0, 32'd8);
`endif
        do_req("st f3=100", 1, 3'b100, 32'd0, 32'h12345678, 1, 32'h0, 1, 0, 0, 32'd0);
        do_req("ld f3=011", 0, 3'b011, 32'd0, 32'h0, 1, 32'h0, 1, 0, 0, 32'd0);
        do_req("lw1024", 0, 3'b010, 32'd1024, 32'h0, 1, 32'h0, 1, 0, 0, 32'd0);
        do_req("lh1023", 0, 3'b001, 32'd1023, 32'h0, 1, 32'h0, 1, 0, 0, 32'd0);
        do_req("lw1020", 0, 3'b010, 32'd1020, 32'h0, 2, 32'h0, 0, 1, 0, 32'd1020);
        check_eq("sw0 intact", {mem_b[3], mem_b[2], mem_b[1], mem_b[0]}, 32'hAABBCCDD);

        // Reset two bytes into a split word store at 33.
        @(negedge clk);
        req_bus.req_valid  = 1'b1;
        req_bus.req_we     = 1'b1;
        req_bus.req_funct3 = 3'b010;
        req_bus.req_addr   = 32'd33;
        req_bus.req_wdata  = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req_bus.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("midrst wr_en", 32'(mem_bus.mem_write_en), 32'd0);
        check_eq("midrst ready", 32'(req_bus.req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_eq("postrst ready", 32'(req_bus.req_ready), 32'd1);
        check_eq("postrst resp", 32'(req_bus.resp_valid), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("postrst wr_en", 32'(mem_bus.mem_write_en), 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        check_eq("split bytes", {mem_b[36], mem_b[35], mem_b[34], mem_b[33]}, 32'h00000000);
`else
        check_eq("split bytes", {mem_b[36], mem_b[35], mem_b[34], mem_b[33]}, 32'h0000F00D);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
